pc_unpacker: RTL and testbench
==============================

// Module: pc_unpacker
// PURPOSE
//  Downstream counterpart of the upward PC packer: accepts 32-bit PC words [route|code|data] from the host link
//  and dispatches each to one of three channels: BD deserializer, FPGA config/register deserializer, or the
//  global (BD-to-BD) tag router. Each output has its own 2-entry buffer, so a stalled consumer blocks only when
//  its own buffer is full (head-of-line at the input). Undecodable words are dropped and counted.
// PARAMETERS
//  NPCcode     7    code field width
//  NPCdata     20   payload field width
//  NPCroute    5    route field width; word width W = NPCroute+NPCcode+NPCdata = 32
//  LOCAL_rt    0    route value addressing this FPGA; any other route -> Global_out
//  NBDcode     14   local codes 0..NBDcode-1 -> BD_out
//  FPGA_lo     14   lowest local code -> FPGA_out
//  FPGA_hi     127  highest local code -> FPGA_out
// PORTS
//  clk        in   1       single clock, all state on posedge
//  reset      in   1       synchronous, active-high
//  PC_in      in   Channel #(W)   {route,code,data} MSB->LSB; v in, a out
//  BD_out     out  SerializedPCWordChannel          code, payload, v out; a in
//  FPGA_out   out  SerializedPCWordChannel          code, payload, v out; a in
//  Global_out out  SerializedPCWordChannelwithRoute route, code, payload, v out; a in
//  drop_count out  16      saturating count of dropped words
// BEHAVIOUR
//  - Handshake: transfer on any Channel when v && a in the same cycle; v never depends combinationally on a.
//  - Reset: all buffers empty; BD_out.v/FPGA_out.v/Global_out.v = 0; drop_count = 0; PC_in.a = 0 while
//    reset is high, 1 on the first cycle after.
//  - Decode (combinational on PC_in.d): rt = d[W-1 -: NPCroute], cd = d[NPCdata +: NPCcode], pl = d[NPCdata-1:0].
//    rt != LOCAL_rt -> Global; else cd < NBDcode -> BD; else FPGA_lo <= cd <= FPGA_hi -> FPGA; else DROP.
//  - PC_in.a = (target buffer count < 2) for BD/FPGA/Global; always 1 for DROP. Computed from registered
//    counts only (no a->a combinational path).
//  - Latency: word accepted in cycle N appears with out.v = 1 in cycle N+1. Throughput 1 word/cycle per
//    output while its consumer keeps a = 1.
//  - Buffer: 2-entry FIFO per output. Push and pop in the same cycle: count unchanged, order preserved.
//    Full (count = 2): no push; the input stalls until pop. Empty: v = 0, and data is don't-care.
//  - Ordering: FIFO order within each output. No ordering guarantee across outputs.
//  - Fields are passed unmodified; Global_out.route = rt. BD/FPGA outputs strip the route.
//  - DROP: drop_count += 1 on accept; it saturates at 16'hFFFF and never wraps.
//  - Reset mid-operation: all buffered words are discarded, and no partial transfer is emitted.
// STRUCTURE
//  - Shared package (pc_pkg): NPCroute/NPCcode/NPCdata, LOCAL_rt, BD/FPGA code bounds, typedef struct packed
//    pc_word_t {route, code, data}, enum {DST_BD, DST_FPGA, DST_GLOBAL, DST_DROP}.
//  - Sub-module channel_fifo2 #(WIDTH): 2-entry valid/ack FIFO with count; instantiated 3x.
//  - Top: decode function, PC_in.a mux, drop counter.
// TESTING
//  1 Reset: hold reset 3 cycles with PC_in.v = 1 -> no out.v, PC_in.a = 0, drop_count = 0.
//  2 Send {0,7'd3,20'hABCDE} -> BD_out code = 3, payload = ABCDE, v = 1 next cycle. Send {0,7'd15,20'h12345}
//    -> FPGA_out code = 15.
//  3 Send {5'd4,7'd2,20'h00001} -> Global_out route = 4, code = 2, payload = 1. BD_out stays idle.
//  4 BD_out.a = 0; send 3 BD words -> first 2 accepted, 3rd stalls with PC_in.a = 0. Meanwhile no FPGA word
//    can pass (head-of-line). Raise a -> words emerge in order, the 3rd is accepted the cycle after the first pop.
//  5 Streaming: 100 back-to-back BD words with a = 1 -> 100 outputs, 1 per cycle, in order.
//  6 Drop: local code 7'd13 when NBDcode = 13 -> drop_count = 1, no output. Force the count to FFFE, then
//    send 3 drops -> drop_count = FFFF.
//  7 Reset with 2 words buffered in FPGA -> after reset FPGA_out.v = 0 and those words are never emitted.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared field widths, routing defaults and word/destination types for the PC downstream path.
package pc_pkg;

    localparam int NPC_ROUTE = 5;
    localparam int NPC_CODE  = 7;
    localparam int NPC_DATA  = 20;
    localparam int PC_W      = NPC_ROUTE + NPC_CODE + NPC_DATA;

    localparam logic [NPC_ROUTE-1:0] LOCAL_RT_DEF = '0;
    localparam logic [NPC_CODE-1:0]  NBD_CODE_DEF = 7'd14;
    localparam logic [NPC_CODE-1:0]  FPGA_LO_DEF  = 7'd14;
    localparam logic [NPC_CODE-1:0]  FPGA_HI_DEF  = 7'd127;

    typedef struct packed {
        logic [NPC_ROUTE-1:0] route;
        logic [NPC_CODE-1:0]  code;
        logic [NPC_DATA-1:0]  data;
    } pc_word_t;

    typedef enum logic [1:0] {
        DST_BD,
        DST_FPGA,
        DST_GLOBAL,
        DST_DROP
    } dest_t;

endpackage

// File: rtl/channel_fifo2.sv
// Two-entry valid/ack FIFO with occupancy count; push is ignored when full.
module channel_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_v,
    input  logic             out_a,
    output logic [WIDTH-1:0] out_d,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign out_v   = (count != 2'd0);
    assign out_d   = mem[rd_ptr];
    assign do_push = push && (count != 2'd2);
    assign do_pop  = out_v && out_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Payload storage needs no reset: out_v masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_unpacker.sv
// Dispatches host PC words to BD, FPGA-config or global-route channels, each behind its own 2-deep buffer.
module pc_unpacker
    import pc_pkg::*;
#(
    parameter logic [NPC_ROUTE-1:0] LOCAL_RT = LOCAL_RT_DEF,
    parameter logic [NPC_CODE-1:0]  NBD_CODE = NBD_CODE_DEF,
    parameter logic [NPC_CODE-1:0]  FPGA_LO  = FPGA_LO_DEF,
    parameter logic [NPC_CODE-1:0]  FPGA_HI  = FPGA_HI_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pc_in_v,
    output logic                 pc_in_a,
    input  logic [PC_W-1:0]      pc_in_d,
    output logic                 bd_out_v,
    input  logic                 bd_out_a,
    output logic [NPC_CODE-1:0]  bd_out_code,
    output logic [NPC_DATA-1:0]  bd_out_payload,
    output logic                 fpga_out_v,
    input  logic                 fpga_out_a,
    output logic [NPC_CODE-1:0]  fpga_out_code,
    output logic [NPC_DATA-1:0]  fpga_out_payload,
    output logic                 global_out_v,
    input  logic                 global_out_a,
    output logic [NPC_ROUTE-1:0] global_out_route,
    output logic [NPC_CODE-1:0]  global_out_code,
    output logic [NPC_DATA-1:0]  global_out_payload,
    output logic [15:0]          drop_count
);

    localparam int LW = NPC_CODE + NPC_DATA;

    // Compares are widened by one bit so a bound at the field maximum is not a constant compare.
    function automatic dest_t decode(input pc_word_t w);
        if (w.route != LOCAL_RT)                                  return DST_GLOBAL;
        if ({1'b0, w.code} < {1'b0, NBD_CODE})                    return DST_BD;
        if (({1'b0, w.code} >= {1'b0, FPGA_LO}) &&
            ({1'b0, w.code} <= {1'b0, FPGA_HI}))                  return DST_FPGA;
        return DST_DROP;
    endfunction

    pc_word_t      word;
    dest_t         dst;
    logic          room;
    logic          accept;
    logic [1:0]    bd_count;
    logic [1:0]    fpga_count;
    logic [1:0]    global_count;
    logic [LW-1:0] bd_d;
    logic [LW-1:0] fpga_d;
    logic [PC_W-1:0] global_d;
    logic [15:0]   drop_q;

    assign word = pc_word_t'(pc_in_d);
    assign dst  = decode(word);

    always_comb begin
        room = 1'b1;
        case (dst)
            DST_BD:     room = (bd_count != 2'd2);
            DST_FPGA:   room = (fpga_count != 2'd2);
            DST_GLOBAL: room = (global_count != 2'd2);
            default:    room = 1'b1;
        endcase
    end

    assign pc_in_a = !reset && room;
    assign accept  = pc_in_v && pc_in_a;

    channel_fifo2 #(.WIDTH(LW)) u_bd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && (dst == DST_BD)),
        .push_data ({word.code, word.data}),
        .out_v     (bd_out_v),
        .out_a     (bd_out_a),
        .out_d     (bd_d),
        .count     (bd_count)
    );

    channel_fifo2 #(.WIDTH(LW)) u_fpga_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && (dst == DST_FPGA)),
        .push_data ({word.code, word.data}),
        .out_v     (fpga_out_v),
        .out_a     (fpga_out_a),
        .out_d     (fpga_d),
        .count     (fpga_count)
    );

    channel_fifo2 #(.WIDTH(PC_W)) u_global_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && (dst == DST_GLOBAL)),
        .push_data (pc_in_d),
        .out_v     (global_out_v),
        .out_a     (global_out_a),
        .out_d     (global_d),
        .count     (global_count)
    );

    assign {bd_out_code, bd_out_payload}     = bd_d;
    assign {fpga_out_code, fpga_out_payload} = fpga_d;
    assign {global_out_route, global_out_code, global_out_payload} = global_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else if (accept && (dst == DST_DROP) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_pc_unpacker.sv
// Scoreboard bench for pc_unpacker: routing model feeds per-output queues, a negedge monitor checks outputs.
module tb_pc_unpacker;

    localparam int NBD = 13;
    localparam int FLO = 14;
    localparam int FHI = 127;
    localparam int LRT = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_in_v;
    logic        pc_in_a;
    logic [31:0] pc_in_d;
    logic        bd_out_v, bd_out_a;
    logic [6:0]  bd_out_code;
    logic [19:0] bd_out_payload;
    logic        fpga_out_v, fpga_out_a;
    logic [6:0]  fpga_out_code;
    logic [19:0] fpga_out_payload;
    logic        global_out_v, global_out_a;
    logic [4:0]  global_out_route;
    logic [6:0]  global_out_code;
    logic [19:0] global_out_payload;
    logic [15:0] drop_count;

    pc_unpacker #(.NBD_CODE(7'd13)) dut (
        .clk                (clk),
        .reset              (reset),
        .pc_in_v            (pc_in_v),
        .pc_in_a            (pc_in_a),
        .pc_in_d            (pc_in_d),
        .bd_out_v           (bd_out_v),
        .bd_out_a           (bd_out_a),
        .bd_out_code        (bd_out_code),
        .bd_out_payload     (bd_out_payload),
        .fpga_out_v         (fpga_out_v),
        .fpga_out_a         (fpga_out_a),
        .fpga_out_code      (fpga_out_code),
        .fpga_out_payload   (fpga_out_payload),
        .global_out_v       (global_out_v),
        .global_out_a       (global_out_a),
        .global_out_route   (global_out_route),
        .global_out_code    (global_out_code),
        .global_out_payload (global_out_payload),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          bd_pops = 0;
    int          last_accept_cyc = 0;
    int          drop_exp = 0;
    bit          rand_ack = 1'b0;
    logic [26:0] q_bd[$];
    logic [26:0] q_fp[$];
    logic [31:0] q_gl[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference routing: 0=BD 1=FPGA 2=GLOBAL 3=DROP, straight from the field arithmetic.
    function automatic int classify(input logic [31:0] w);
        int rt;
        int cd;
        rt = int'(w >> 27);
        cd = int'((w >> 20) & 32'd127);
        if (rt != LRT) return 2;
        if (cd < NBD) return 0;
        if (cd >= FLO && cd <= FHI) return 1;
        return 3;
    endfunction

    task automatic expect_word(input logic [31:0] w);
        case (classify(w))
            0: q_bd.push_back(w[26:0]);
            1: q_fp.push_back(w[26:0]);
            2: q_gl.push_back(w);
            default: if (drop_exp < 65535) drop_exp++;
        endcase
    endtask

    task automatic rand_acks();
        bd_out_a     = 1'($urandom_range(0, 1));
        fpga_out_a   = 1'($urandom_range(0, 1));
        global_out_a = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        pc_in_v = 1'b1;
        pc_in_d = w;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (pc_in_a) begin
                expect_word(w);
                last_accept_cyc = cyc;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rand_ack) rand_acks();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accept word=%h", w);
        end
        pc_in_v = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bd_out_v && bd_out_a) begin
                bd_pops++;
                if (q_bd.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bd_spurious actual=%h required=none", {bd_out_code, bd_out_payload});
                end else chk("bd_word", 32'({bd_out_code, bd_out_payload}), 32'(q_bd.pop_front()));
            end
            if (fpga_out_v && fpga_out_a) begin
                if (q_fp.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL fpga_spurious actual=%h required=none", {fpga_out_code, fpga_out_payload});
                end else chk("fpga_word", 32'({fpga_out_code, fpga_out_payload}), 32'(q_fp.pop_front()));
            end
            if (global_out_v && global_out_a) begin
                if (q_gl.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL global_spurious actual=%h required=none",
                             {global_out_route, global_out_code, global_out_payload});
                end else chk("global_word", {global_out_route, global_out_code, global_out_payload},
                             q_gl.pop_front());
            end
        end
    end

    function automatic logic [31:0] mk(input int rt, input int cd, input int pl);
        logic [31:0] w;
        w = 32'((rt & 31) << 27) | 32'((cd & 127) << 20) | 32'(pl & 32'hFFFFF);
        return w;
    endfunction

    initial begin
        int first_cyc;
        int pops0;
        logic [31:0] w;

        reset = 1'b1;
        pc_in_v = 1'b1;
        pc_in_d = mk(0, 3, 20'h11111);
        bd_out_a = 1'b1;
        fpga_out_a = 1'b1;
        global_out_a = 1'b1;

        // 1: reset holds everything quiet even with input valid
        repeat (3) begin
            @(negedge clk);
            chk("rst_pc_in_a", 32'(pc_in_a), 32'd0);
            chk("rst_out_v", 32'({bd_out_v, fpga_out_v, global_out_v}), 32'd0);
            chk("rst_drop_count", 32'(drop_count), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        pc_in_v = 1'b0;
        @(negedge clk);
        chk("post_rst_pc_in_a", 32'(pc_in_a), 32'd1);
        @(posedge clk); #1;

        // 2: BD and FPGA routing, one-cycle latency
        send(mk(0, 3, 20'hABCDE));
        @(negedge clk);
        chk("bd_v_next", 32'(bd_out_v), 32'd1);
        chk("bd_code", 32'(bd_out_code), 32'd3);
        chk("bd_payload", 32'(bd_out_payload), 32'hABCDE);
        @(posedge clk); #1;
        send(mk(0, 15, 20'h12345));
        @(negedge clk);
        chk("fpga_v_next", 32'(fpga_out_v), 32'd1);
        chk("fpga_code", 32'(fpga_out_code), 32'd15);
        @(posedge clk); #1;

        // 3: global route keeps the route field
        send(mk(4, 2, 1));
        @(negedge clk);
        chk("gl_v", 32'(global_out_v), 32'd1);
        chk("gl_route", 32'(global_out_route), 32'd4);
        chk("gl_code", 32'(global_out_code), 32'd2);
        chk("gl_payload", 32'(global_out_payload), 32'd1);
        chk("gl_bd_idle", 32'(bd_out_v), 32'd0);
        @(posedge clk); #1;

        // 4: BD stalled consumer -> third word blocks the input
        bd_out_a = 1'b0;
        send(mk(0, 1, 20'h00A01));
        send(mk(0, 2, 20'h00A02));
        w = mk(0, 5, 20'h00A03);
        pc_in_v = 1'b1;
        pc_in_d = w;
        repeat (3) begin
            @(negedge clk);
            chk("hol_stall_a", 32'(pc_in_a), 32'd0);
            chk("hol_fpga_idle", 32'(fpga_out_v), 32'd0);
            @(posedge clk); #1;
        end
        bd_out_a = 1'b1;
        @(negedge clk);
        chk("hol_a_at_pop", 32'(pc_in_a), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hol_a_after_pop", 32'(pc_in_a), 32'd1);
        if (pc_in_a) expect_word(w);
        @(posedge clk); #1;
        pc_in_v = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 5: back-to-back streaming
        pops0 = bd_pops;
        send(mk(0, 0, 0));
        first_cyc = last_accept_cyc;
        for (int i = 1; i < 100; i++) send(mk(0, i % 13, i));
        chk("stream_span", 32'(last_accept_cyc - first_cyc), 32'd99);
        repeat (4) @(posedge clk);
        #1;
        chk("stream_pops", 32'(bd_pops - pops0), 32'd100);

        // 6: drops and saturation
        send(mk(0, 13, 5));
        repeat (2) @(negedge clk);
        chk("drop_one", 32'(drop_count), 32'(drop_exp));
        chk("drop_no_out", 32'({bd_out_v, fpga_out_v, global_out_v}), 32'd0);
        @(posedge clk); #1;
        force dut.drop_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.drop_q;
        drop_exp = 16'hFFFE;
        repeat (3) send(mk(0, 13, 7));
        @(negedge clk);
        chk("drop_saturate", 32'(drop_count), 32'(drop_exp));
        @(posedge clk); #1;

        // 7: reset discards buffered FPGA words
        fpga_out_a = 1'b0;
        send(mk(0, 20, 20'h0F001));
        send(mk(0, 21, 20'h0F002));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q_bd.delete();
        q_fp.delete();
        q_gl.delete();
        drop_exp = 0;
        @(negedge clk);
        chk("rst_mid_fpga_v", 32'(fpga_out_v), 32'd0);
        chk("rst_mid_drop", 32'(drop_count), 32'd0);
        fpga_out_a = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_mid_quiet", 32'(fpga_out_v), 32'd0);
        end
        @(posedge clk); #1;

        // Randomized mix with random consumer back-pressure
        rand_ack = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            int rt;
            int cd;
            r  = int'($urandom_range(0, 9));
            rt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 0;
            if (r < 4)       cd = int'($urandom_range(0, 12));
            else if (r < 8)  cd = int'($urandom_range(14, 127));
            else if (r == 8) cd = 13;
            else             cd = int'($urandom_range(0, 127));
            send(mk(rt, cd, int'($urandom)));
            repeat (int'($urandom_range(0, 1))) begin
                @(posedge clk); #1;
                rand_acks();
            end
        end
        rand_ack = 1'b0;
        bd_out_a = 1'b1;
        fpga_out_a = 1'b1;
        global_out_a = 1'b1;
        for (int i = 0; i < 50 && (q_bd.size() + q_fp.size() + q_gl.size()) != 0; i++) @(posedge clk);
        #1;
        chk("drain_bd", 32'(q_bd.size()), 32'd0);
        chk("drain_fpga", 32'(q_fp.size()), 32'd0);
        chk("drain_global", 32'(q_gl.size()), 32'd0);
        @(negedge clk);
        chk("final_drop_count", 32'(drop_count), 32'(drop_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
